seven_segment_reader: RTL

- Monitors a multiplexed 4-digit seven-segment bus (active-low anodes and cathodes, the same bus the display driver produces) and recovers per-digit hex values and decimal points.
- Used as an on-board monitor/loopback checker for display drivers and as a bench-side observer.
- Synchronises the bus, filters ghosting with a stability counter and decodes glyphs.
- Reports completed frames and ages out digits that stop refreshing.

---
 rtl/seven_segment_pkg.sv | 43 ++++
 rtl/seven_segment_glyph_decoder.sv | 23 ++
 rtl/seven_segment_reader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/seven_segment_pkg.sv
// Shared seven-segment definitions: glyph table, segment bit positions and
// anode helpers, common to the bus reader and the display driver.
package seven_segment_pkg;

  localparam int NUM_DIGITS = 4;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high gfedcba patterns, indexed by the hex value they display.
  localparam logic [6:0] GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [2:0] count_low(input logic [NUM_DIGITS-1:0] an);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      n = n + {2'b00, ~an[i]};
    end
    return n;
  endfunction

  function automatic logic [1:0] low_index(input logic [NUM_DIGITS-1:0] an);
    logic [1:0] idx;
    case (an)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/seven_segment_glyph_decoder.sv
// Combinational glyph lookup: active-high gfedcba segments to hex value,
// with separate flags for a table hit and an all-dark (blank) pattern.
module seven_segment_glyph_decoder
  import seven_segment_pkg::*;
(
  input  logic [6:0] segs,
  output logic       hit,
  output logic       blank,
  output logic [3:0] value
);

  // Table entries are unique, so at most one match contributes a value.
  always_comb begin
    hit   = 1'b0;
    value = 4'h0;
    for (int i = 0; i < 16; i++) begin
      hit   = hit | (segs == GLYPHS[i]);
      value = (segs == GLYPHS[i]) ? 4'(i) : value;
    end
    blank = (segs == 7'h00);
  end

endmodule

// File: rtl/seven_segment_reader.sv
// Observer for a multiplexed 4-digit active-low seven-segment bus: recovers
// per-digit hex values and decimal points, flags bad glyphs/anodes, ages out stale digits.
module seven_segment_reader
  import seven_segment_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_W          = 21
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anodes,
  input  logic [7:0]  cathodes,
  output logic [15:0] values,
  output logic [3:0]  dps,
  output logic [3:0]  valid,
  output logic        frame_done,
  output logic        glyph_error,
  output logic        anode_error
);

  localparam logic [CNT_W-1:0] DWELL_AT = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_AT   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  // Synchroniser idles at "all anodes off" so reset never looks like a lit digit.
  localparam logic [11:0]      IDLE_BUS = 12'hFFF;

  logic [11:0]                      sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [CNT_W-1:0]                 stab_q, stab_d;
  logic [NUM_DIGITS-1:0][CNT_W-1:0] tmo_q, tmo_d;
  logic [15:0]                      values_q, values_d;
  logic [3:0]                       dps_q, dps_d, valid_q, valid_d, captured_q, captured_d;
  logic                             frame_done_q, frame_done_d;
  logic                             glyph_error_q, glyph_error_d;
  logic                             anode_error_q, anode_error_d;

  logic [3:0] an_s;
  logic [6:0] segs_s;
  logic       dp_lit_s;
  logic       dwell_s;
  logic [2:0] nlow_s;
  logic [1:0] dig_s;
  logic       hit_s, blank_s;
  logic [3:0] glyph_val_s;
  logic [3:0] mark_s;

  seven_segment_glyph_decoder u_decoder (
    .segs  (segs_s),
    .hit   (hit_s),
    .blank (blank_s),
    .value (glyph_val_s)
  );

  // Input path and stability counter; dwell_s fires once per stable run.
  always_comb begin
    sync1_d  = {anodes, cathodes};
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    an_s     = sync2_q[11:8];
    segs_s   = ~sync2_q[SEG_G:SEG_A];
    dp_lit_s = ~sync2_q[SEG_DP];
    nlow_s   = count_low(an_s);
    dig_s    = low_index(an_s);
    if (sync2_q != prev_q) begin
      stab_d = CNT_ZERO;
    end else if (stab_q == CNT_MAX) begin
      stab_d = stab_q;
    end else begin
      stab_d = stab_q + CNT_ONE;
    end
    dwell_s = (stab_d == DWELL_AT);
  end

  // Digit state update; captures are applied after timeouts so they win.
  always_comb begin
    values_d      = values_q;
    dps_d         = dps_q;
    valid_d       = valid_q;
    tmo_d         = tmo_q;
    mark_s        = 4'b0000;
    glyph_error_d = 1'b0;
    anode_error_d = 1'b0;

    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (tmo_q[d] == TMO_AT) begin
        tmo_d[d] = tmo_q[d];
      end else begin
        tmo_d[d] = tmo_q[d] + CNT_ONE;
        if (tmo_d[d] == TMO_AT) begin
          valid_d[d] = 1'b0;
        end else begin
          valid_d[d] = valid_q[d];
        end
      end
    end

    if (dwell_s) begin
      case (nlow_s)
        3'd0: mark_s = 4'b0000;
        3'd1: begin
          if (hit_s) begin
            values_d[{dig_s, 2'b00} +: 4] = glyph_val_s;
            dps_d[dig_s]   = dp_lit_s;
            valid_d[dig_s] = 1'b1;
            mark_s[dig_s]  = 1'b1;
            tmo_d[dig_s]   = CNT_ZERO;
          end else if (blank_s) begin
            valid_d[dig_s] = 1'b0;
            mark_s[dig_s]  = 1'b1;
            tmo_d[dig_s]   = CNT_ZERO;
          end else begin
            glyph_error_d  = 1'b1;
            valid_d[dig_s] = 1'b0;
          end
        end
        default: anode_error_d = 1'b1;
      endcase
    end else begin
      anode_error_d = 1'b0;
    end

    // A full set is reported one cycle late; captures in that cycle start the next frame.
    if (captured_q == 4'b1111) begin
      frame_done_d = 1'b1;
      captured_d   = mark_s;
    end else begin
      frame_done_d = 1'b0;
      captured_d   = captured_q | mark_s;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q       <= IDLE_BUS;
      sync2_q       <= IDLE_BUS;
      prev_q        <= IDLE_BUS;
      stab_q        <= CNT_ZERO;
      tmo_q         <= {NUM_DIGITS{CNT_ZERO}};
      values_q      <= 16'h0000;
      dps_q         <= 4'h0;
      valid_q       <= 4'h0;
      captured_q    <= 4'h0;
      frame_done_q  <= 1'b0;
      glyph_error_q <= 1'b0;
      anode_error_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      stab_q        <= stab_d;
      tmo_q         <= tmo_d;
      values_q      <= values_d;
      dps_q         <= dps_d;
      valid_q       <= valid_d;
      captured_q    <= captured_d;
      frame_done_q  <= frame_done_d;
      glyph_error_q <= glyph_error_d;
      anode_error_q <= anode_error_d;
    end
  end

  assign values      = values_q;
  assign dps         = dps_q;
  assign valid       = valid_q;
  assign frame_done  = frame_done_q;
  assign glyph_error = glyph_error_q;
  assign anode_error = anode_error_q;

endmodule
